// File: rtl/uart_receiver.sv
// 8N1 UART receive stage: oversampled start/data/stop capture with a sticky ready flag,
// an overrun flag and a single-cycle framing-error pulse.
module uart_receiver #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk_5m,
  input  logic       rst_n,
  input  logic       rx,
  input  logic       clken_16x,
  input  logic       rdy_clr,
  output logic [7:0] dout,
  output logic       rdy,
  output logic       overrun,
  output logic       ferr,
  output logic       rx_busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] HALF_M1 = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(OVERSAMPLE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t         state_r;
  logic [CW-1:0]  sample_cnt_r;
  logic [2:0]     bitpos_r;
  logic [7:0]     shift_r;
  logic           rx_meta_r;
  logic           rx_s;

  // Two-flop synchroniser for the asynchronous serial line; resets to idle-high.
  always_ff @(posedge clk_5m or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_r <= 1'b1;
      rx_s      <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_s      <= rx_meta_r;
    end
  end

  assign rx_busy = (state_r != IDLE);

  // Frame FSM and output flags; later assignments give a completing byte priority over rdy_clr.
  always_ff @(posedge clk_5m or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      sample_cnt_r <= '0;
      bitpos_r     <= 3'd0;
      shift_r      <= 8'h00;
      dout         <= 8'h00;
      rdy          <= 1'b0;
      overrun      <= 1'b0;
      ferr         <= 1'b0;
    end else begin
      ferr <= 1'b0;
      if (rdy_clr) begin
        rdy     <= 1'b0;
        overrun <= 1'b0;
      end
      if (clken_16x) begin
        case (state_r)
          IDLE: begin
            if (!rx_s) begin
              state_r      <= START;
              sample_cnt_r <= '0;
            end
          end
          START: begin
            if (sample_cnt_r == HALF_M1) begin
              sample_cnt_r <= '0;
              bitpos_r     <= 3'd0;
              state_r      <= rx_s ? IDLE : DATA;
            end else begin
              sample_cnt_r <= sample_cnt_r + CW'(1);
            end
          end
          DATA: begin
            if (sample_cnt_r == FULL_M1) begin
              shift_r[bitpos_r] <= rx_s;
              sample_cnt_r      <= '0;
              if (bitpos_r == 3'd7) begin
                state_r <= STOP;
              end else begin
                bitpos_r <= bitpos_r + 3'd1;
              end
            end else begin
              sample_cnt_r <= sample_cnt_r + CW'(1);
            end
          end
          STOP: begin
            if (sample_cnt_r == FULL_M1) begin
              sample_cnt_r <= '0;
              state_r      <= IDLE;
              if (rx_s) begin
                dout <= shift_r;
                rdy  <= 1'b1;
                if (rdy && !rdy_clr) begin
                  overrun <= 1'b1;
                end
              end else begin
                ferr <= 1'b1;
              end
            end else begin
              sample_cnt_r <= sample_cnt_r + CW'(1);
            end
          end
          default: begin
            state_r      <= IDLE;
            sample_cnt_r <= '0;
          end
        endcase
      end
    end
  end

endmodule
